// File: rtl/ps2_pkg.sv
// Shared constants, event layout, state encoding and helpers for the PS/2 key event receiver.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Event word: {ext, brk, code[7:0]}
    localparam int EV_W        = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } frame_state_t;

    // PS/2 uses odd parity over data plus parity bit
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic logic [EV_W-1:0] pack_event(input logic ext, input logic brk,
                                                   input logic [7:0] code);
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Valid/ready key event port between the PS/2 front end and the scancode consumer.
interface ps2_key_event_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (output ev_valid, output ev_code, output ev_ext, output ev_brk,
                    input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_ext, input ev_brk,
                    output ev_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchronisers, ps2_clk glitch filter and 11-bit frame receiver with idle timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   sync_clk_s;
    logic                   sync_data_s;
    logic                   filt_r;
    logic                   filt_next_s;
    logic [FW-1:0]          fcnt_r;
    logic [FW-1:0]          fcnt_next_s;
    logic                   strobe_s;

    frame_state_t state_r;
    frame_state_t state_next_s;
    logic [3:0]   bit_cnt_r;
    logic [3:0]   bit_cnt_next_s;
    logic [7:0]   shift_r;
    logic [7:0]   shift_next_s;
    logic         par_r;
    logic         par_next_s;
    logic [TW-1:0] to_cnt_r;
    logic [TW-1:0] to_cnt_next_s;
    logic [7:0]   byte_r;
    logic [7:0]   byte_next_s;
    logic         byte_ok_r;
    logic         byte_ok_next_s;
    logic         err_r;
    logic         err_next_s;

    assign sync_clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign sync_data_s = data_sync_r[SYNC_STAGES-1];
    assign rx_byte     = byte_r;
    assign byte_ok     = byte_ok_r;
    assign frame_err   = err_r;

    // Metastability synchronisers for both asynchronous pins (idle level is high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Glitch filter: a new ps2_clk level must persist FILTER_LEN cycles; strobe on accepted fall
    always_comb begin
        filt_next_s = filt_r;
        fcnt_next_s = {FW{1'b0}};
        strobe_s    = 1'b0;
        if (sync_clk_s != filt_r) begin
            if (fcnt_r == FW'(FILTER_LEN - 1)) begin
                filt_next_s = sync_clk_s;
                strobe_s    = ~sync_clk_s;
            end else begin
                fcnt_next_s = fcnt_r + FW'(1'b1);
            end
        end else begin
            fcnt_next_s = {FW{1'b0}};
        end
    end

    // Frame FSM next-state, bit capture, stop-bit check and timeout
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        shift_next_s   = shift_r;
        par_next_s     = par_r;
        to_cnt_next_s  = to_cnt_r;
        byte_next_s    = byte_r;
        byte_ok_next_s = 1'b0;
        err_next_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                to_cnt_next_s  = {TW{1'b0}};
                bit_cnt_next_s = 4'd0;
                if (strobe_s && !sync_data_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA, ST_STOP: begin
                if (strobe_s) begin
                    to_cnt_next_s = {TW{1'b0}};
                    if (state_r == ST_STOP) begin
                        state_next_s = ST_IDLE;
                        if (sync_data_s && parity_ok(shift_r, par_r)) begin
                            byte_ok_next_s = 1'b1;
                            byte_next_s    = shift_r;
                        end else begin
                            err_next_s = 1'b1;
                        end
                    end else if (bit_cnt_r == 4'd8) begin
                        par_next_s   = sync_data_s;
                        state_next_s = ST_STOP;
                    end else begin
                        shift_next_s   = {sync_data_s, shift_r[7:1]};
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                    end
                end else if (to_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
                    state_next_s  = ST_IDLE;
                    to_cnt_next_s = {TW{1'b0}};
                    err_next_s    = 1'b1;
                end else begin
                    to_cnt_next_s = to_cnt_r + TW'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Filter and frame state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r    <= 1'b1;
            fcnt_r    <= {FW{1'b0}};
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'd0;
            par_r     <= 1'b0;
            to_cnt_r  <= {TW{1'b0}};
            byte_r    <= 8'd0;
            byte_ok_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            filt_r    <= filt_next_s;
            fcnt_r    <= fcnt_next_s;
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            shift_r   <= shift_next_s;
            par_r     <= par_next_s;
            to_cnt_r  <= to_cnt_next_s;
            byte_r    <= byte_next_s;
            byte_ok_r <= byte_ok_next_s;
            err_r     <= err_next_s;
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard front end: folds E0/F0 prefixes into key events, tracks modifiers, queues events.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ps2_clk,
    input  logic                    ps2_data,
    ps2_key_event_rx_if.master      ev,
    output logic [3:0]              mods,
    output logic                    frame_err,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]      rx_byte_s;
    logic            byte_ok_s;
    logic            rx_err_s;

    logic            ext_pend_r, brk_pend_r;
    logic            ext_next_s, brk_next_s;
    logic            emit_s;
    logic [EV_W-1:0] ev_data_s;

    logic            shift_r, ctrl_r, alt_r, caps_r, caps_held_r;
    logic            shift_next_s, ctrl_next_s, alt_next_s, caps_next_s, caps_held_next_s;

    logic [EV_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]   count_r, count_next_s;
    logic            push_do_s, pop_s, drop_s, full_s;
    logic [EV_W-1:0] head_r, head_next_s;
    logic            valid_r;
    logic            ovf_r, ovf_next_s;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte_s),
        .byte_ok   (byte_ok_s),
        .frame_err (rx_err_s)
    );

    assign ev.ev_valid = valid_r;
    assign ev.ev_code  = head_r[EV_CODE_LSB +: 8];
    assign ev.ev_brk   = head_r[EV_BRK_BIT];
    assign ev.ev_ext   = head_r[EV_EXT_BIT];
    assign mods        = {caps_r, alt_r, ctrl_r, shift_r};
    assign frame_err   = rx_err_s;
    assign overflow    = ovf_r;

    // Prefix folding: E0/F0 only arm flags; any other byte emits; a rejected frame disarms
    always_comb begin
        emit_s     = 1'b0;
        ext_next_s = ext_pend_r;
        brk_next_s = brk_pend_r;
        ev_data_s  = pack_event(ext_pend_r, brk_pend_r, rx_byte_s);
        if (rx_err_s) begin
            ext_next_s = 1'b0;
            brk_next_s = 1'b0;
        end else if (byte_ok_s) begin
            if (rx_byte_s == SC_EXT) begin
                ext_next_s = 1'b1;
            end else if (rx_byte_s == SC_BRK) begin
                brk_next_s = 1'b1;
            end else begin
                emit_s     = 1'b1;
                ext_next_s = 1'b0;
                brk_next_s = 1'b0;
            end
        end else begin
            emit_s = 1'b0;
        end
    end

    // Modifier tracking; caps_held suppresses retoggling on typematic repeats
    always_comb begin
        shift_next_s     = shift_r;
        ctrl_next_s      = ctrl_r;
        alt_next_s       = alt_r;
        caps_next_s      = caps_r;
        caps_held_next_s = caps_held_r;
        if (emit_s) begin
            case (rx_byte_s)
                SC_LSHIFT, SC_RSHIFT: begin
                    if (!ext_pend_r) begin
                        shift_next_s = ~brk_pend_r;
                    end else begin
                        shift_next_s = shift_r;
                    end
                end
                SC_CTRL: ctrl_next_s = ~brk_pend_r;
                SC_ALT:  alt_next_s  = ~brk_pend_r;
                SC_CAPS: begin
                    if (brk_pend_r) begin
                        caps_held_next_s = 1'b0;
                    end else begin
                        caps_next_s      = caps_held_r ? caps_r : ~caps_r;
                        caps_held_next_s = 1'b1;
                    end
                end
                default: caps_held_next_s = caps_held_r;
            endcase
        end else begin
            caps_held_next_s = caps_held_r;
        end
    end

    // FIFO bookkeeping; the head register is loaded from the post-update queue state
    always_comb begin
        full_s        = (count_r == CW'(FIFO_DEPTH));
        pop_s         = valid_r && ev.ev_ready;
        push_do_s     = emit_s && (!full_s || pop_s);
        drop_s        = emit_s && full_s && !pop_s;
        wr_ptr_next_s = push_do_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
        rd_ptr_next_s = pop_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
        case ({push_do_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {EV_W{1'b0}};
        end else if (push_do_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = ev_data_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Decoder, modifier, FIFO and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            shift_r     <= 1'b0;
            ctrl_r      <= 1'b0;
            alt_r       <= 1'b0;
            caps_r      <= 1'b0;
            caps_held_r <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            head_r      <= {EV_W{1'b0}};
            valid_r     <= 1'b0;
            ovf_r       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EV_W{1'b0}};
            end
        end else begin
            ext_pend_r  <= ext_next_s;
            brk_pend_r  <= brk_next_s;
            shift_r     <= shift_next_s;
            ctrl_r      <= ctrl_next_s;
            alt_r       <= alt_next_s;
            caps_r      <= caps_next_s;
            caps_held_r <= caps_held_next_s;
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            head_r      <= head_next_s;
            valid_r     <= (count_next_s != {CW{1'b0}});
            ovf_r       <= ovf_next_s;
            if (push_do_s) begin
                mem_r[wr_ptr_r] <= ev_data_s;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench: drives PS/2 frames on the pins and checks queued events, modifiers and errors.
module tb_ps2_key_event_rx;

    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] mods;
    logic       frame_err;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int err_cnt  = 0;

    logic [7:0] ovf_codes [9] = '{8'h1A, 8'h1B, 8'h21, 8'h22, 8'h23, 8'h24, 8'h2B, 8'h2C, 8'h2D};

    ps2_key_event_rx_if ev_if ();

    ps2_key_event_rx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (3),
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev        (ev_if),
        .mods      (mods),
        .frame_err (frame_err),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
    endtask

    task automatic pop_ev(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, {31'd0, ev_if.ev_valid}, 32'd1);
        check(tag, {22'd0, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, {22'd0, exp});
        ev_if.ev_ready = 1'b1;
        tick(1);
        ev_if.ev_ready = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        ev_if.ev_ready = 1'b0;
        tick(5);
        check("rst_valid", {31'd0, ev_if.ev_valid}, 32'd0);
        rst = 1'b0;
        tick(5);
        check("rst_event", {22'd0, ev_if.ev_ext, ev_if.ev_brk, ev_if.ev_code}, 32'd0);
        check("rst_mods", {28'd0, mods}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // make / break of a plain key
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        pop_ev("make_1c", 10'h01C);
        pop_ev("brk_1c", 10'h11C);
        check("empty_after_1c", {31'd0, ev_if.ev_valid}, 32'd0);
        check("empty_code", {24'd0, ev_if.ev_code}, 32'd0);
        check("mods_1c", {28'd0, mods}, 32'd0);

        // extended ctrl
        send_frame(8'hE0, 1'b0);
        send_frame(8'h14, 1'b0);
        check("ctrl_on", {28'd0, mods}, 32'h2);
        pop_ev("ext_make_14", 10'h214);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        check("ctrl_off", {28'd0, mods}, 32'h0);
        pop_ev("ext_brk_14", 10'h314);

        // shift, including extended 0x12 which is not a shift
        send_frame(8'h12, 1'b0);
        check("shift_on", {28'd0, mods}, 32'h1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("shift_off", {28'd0, mods}, 32'h0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("ext12_no_shift", {28'd0, mods}, 32'h0);
        pop_ev("shift_make", 10'h012);
        pop_ev("shift_brk", 10'h112);
        pop_ev("ext12", 10'h212);

        // caps lock with typematic repeats
        send_frame(8'h58, 1'b0);
        check("caps_first", {28'd0, mods}, 32'h8);
        send_frame(8'h58, 1'b0);
        send_frame(8'h58, 1'b0);
        check("caps_repeat", {28'd0, mods}, 32'h8);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h58, 1'b0);
        check("caps_release", {28'd0, mods}, 32'h8);
        send_frame(8'h58, 1'b0);
        check("caps_toggle_off", {28'd0, mods}, 32'h0);
        pop_ev("caps_ev0", 10'h058);
        pop_ev("caps_ev1", 10'h058);
        pop_ev("caps_ev2", 10'h058);
        pop_ev("caps_ev3", 10'h158);
        pop_ev("caps_ev4", 10'h058);
        check("caps_drained", {31'd0, ev_if.ev_valid}, 32'd0);

        // bad parity drops the frame and the pending E0
        base = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h32, 1'b0);
        check("parity_err_cnt", err_cnt - base, 32'd1);
        pop_ev("after_bad_32", 10'h032);
        check("after_bad_empty", {31'd0, ev_if.ev_valid}, 32'd0);

        // glitch shorter than the filter must not start a frame
        base = err_cnt;
        ps2_data = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(10);
        send_frame(8'h21, 1'b0);
        pop_ev("after_glitch", 10'h021);
        check("glitch_no_err", err_cnt - base, 32'd0);

        // frame stalled after 4 bits is aborted by the timeout
        base = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n = 0;
        while (err_cnt == base && n < TIMEOUT_CYC + 1000) begin
            tick(1);
            n++;
        end
        check("timeout_err", err_cnt - base, 32'd1);
        check("timeout_latency", {31'd0, (n >= TIMEOUT_CYC - 100) && (n <= TIMEOUT_CYC + 50)}, 32'd1);
        check("timeout_no_event", {31'd0, ev_if.ev_valid}, 32'd0);
        send_frame(8'h2B, 1'b0);
        pop_ev("after_timeout", 10'h02B);

        // overflow: one more make than the FIFO holds
        for (int i = 0; i < 9; i++) begin
            send_frame(ovf_codes[i], 1'b0);
            if (i == 0) check("ovf_first_valid", {31'd0, ev_if.ev_valid}, 32'd1);
            if (i == 7) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
            if (i == 8) check("ovf_set", {31'd0, overflow}, 32'd1);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pop_ev($sformatf("drain%0d", i), {2'b00, ovf_codes[i]});
        end
        check("drain_empty", {31'd0, ev_if.ev_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
